spi_frame_ctrl: RTL and testbench

//   Clock-domain SPI slave frame controller (mode 0: CPOL=0, CPHA=0) for the roll-display path.

---
 rtl/spi_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl
//   SPI slave frame controller (mode 0: CPOL=0, CPHA=0) for the roll-display
//   path. The raw SPI pins are oversampled on the system clock. Transfers are
//   framed by nss. Each frame shifts in FRAME_BITS bits and returns i_tx_word
//   on o_sdo. Only complete, correctly sized frames reach the display logic.
//   Short or long frames raise a one-clock error pulse and are dropped.
//   The system clock must run at least 4x faster than sck.
//
// Ports
//   i_clk          system clock, all logic on posedge
//   i_rst_raw      synchronous active-low reset
//   i_sck          SPI clock from master (asynchronous to i_clk)
//   i_sdi          SPI data from master
//   i_nss          SPI slave select, active-low
//   o_sdo          SPI data to master
//   i_tx_word      word returned to master, latched at frame start
//   o_frame_data   last valid frame received, MSB = first bit on the wire
//   o_frame_valid  1-clk pulse: o_frame_data just updated
//   o_frame_err    1-clk pulse: frame ended with bit count != FRAME_BITS
//   o_busy         high while the FSM is not idle
//   o_frame_count  count of valid frames, wraps 255 -> 0
//
// FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for an nss falling edge, sdo held low
//   S_ACTIVE | frame in progress: shift on sck edges, leave on nss rise
//   S_FINISH | one cycle: publish the frame or flag an error, then idle
// -----------------------------------------------------------------------------
module spi_frame_ctrl #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_raw,
    input  logic                  i_sck,
    input  logic                  i_sdi,
    input  logic                  i_nss,
    output logic                  o_sdo,
    input  logic [FRAME_BITS-1:0] i_tx_word,
    output logic [FRAME_BITS-1:0] o_frame_data,
    output logic                  o_frame_valid,
    output logic                  o_frame_err,
    output logic                  o_busy,
    output logic [7:0]            o_frame_count
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam int FW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] C_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] C_SAT  = CW'(FRAME_BITS + 1);
    localparam logic [FW-1:0] C_FILL = FW'(SYNC_STAGES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // ---------------------------------------------------------------- pins
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_nss_sync;
    logic                   r_sck_d;
    logic                   r_nss_d;

    logic w_sck;
    logic w_sdi;
    logic w_nss;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_nss_rise;
    logic w_nss_fall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_raw) begin
            r_sck_sync <= '0;
            r_sdi_sync <= '0;
            r_nss_sync <= '1;
            r_sck_d    <= 1'b0;
            r_nss_d    <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
            r_nss_sync <= {r_nss_sync[SYNC_STAGES-2:0], i_nss};
            r_sck_d    <= w_sck;
            r_nss_d    <= w_nss;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
    assign w_nss      = r_nss_sync[SYNC_STAGES-1];
    assign w_sck_rise =  w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck &  r_sck_d;
    assign w_nss_rise =  w_nss & ~r_nss_d;
    assign w_nss_fall = ~w_nss &  r_nss_d;

    // ----------------------------------------------------------- arming
    // The nss synchronizer comes out of reset holding 1. If the master is
    // already mid-frame at reset release, the pipeline then flushes to 0 and
    // looks like a falling edge. To ignore that frame, a start is accepted
    // only after nss has been seen high on a pin-derived sample, i.e. once
    // the reset value has fully drained out of the synchronizer.
    logic [FW-1:0] r_fill_cnt;
    logic          r_armed;
    logic          w_fill_done;

    assign w_fill_done = (r_fill_cnt == C_FILL);

    always_ff @(posedge i_clk) begin
        if (!i_rst_raw) begin
            r_fill_cnt <= '0;
            r_armed    <= 1'b0;
        end else begin
            if (!w_fill_done) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            if (w_fill_done && w_nss) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- FSM
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_bit_cnt;
    logic [CW-1:0]         w_bit_cnt_nxt;
    logic [FRAME_BITS-1:0] r_tx_sh;
    logic [FRAME_BITS-1:0] w_tx_sh_nxt;
    logic [FRAME_BITS-1:0] r_rx_sh;
    logic [FRAME_BITS-1:0] w_rx_sh_nxt;
    logic                  r_sdo;
    logic                  w_sdo_nxt;
    logic [FRAME_BITS-1:0] r_frame_data;
    logic [FRAME_BITS-1:0] w_frame_data_nxt;
    logic                  r_frame_valid;
    logic                  w_frame_valid_nxt;
    logic                  r_frame_err;
    logic                  w_frame_err_nxt;
    logic [7:0]            r_frame_count;
    logic [7:0]            w_frame_count_nxt;
    logic                  r_busy;

    always_ff @(posedge i_clk) begin
        if (!i_rst_raw) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_tx_sh       <= '0;
            r_rx_sh       <= '0;
            r_sdo         <= 1'b0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_tx_sh       <= w_tx_sh_nxt;
            r_rx_sh       <= w_rx_sh_nxt;
            r_sdo         <= w_sdo_nxt;
            r_frame_data  <= w_frame_data_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_tx_sh_nxt       = r_tx_sh;
        w_rx_sh_nxt       = r_rx_sh;
        w_sdo_nxt         = r_sdo;
        w_frame_data_nxt  = r_frame_data;
        w_frame_valid_nxt = 1'b0;
        w_frame_err_nxt   = 1'b0;
        w_frame_count_nxt = r_frame_count;

        case (r_state)
            S_IDLE: begin
                w_sdo_nxt = 1'b0;
                if (w_nss_fall && r_armed) begin
                    w_bit_cnt_nxt = '0;
                    w_tx_sh_nxt   = i_tx_word;
                    w_sdo_nxt     = i_tx_word[FRAME_BITS-1];
                    w_state_nxt   = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                // End of frame wins over any sck edge seen in the same cycle.
                if (w_nss_rise) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    if (w_sck_rise) begin
                        w_rx_sh_nxt = {r_rx_sh[FRAME_BITS-2:0], w_sdi};
                        // Saturate one past full so long frames stay distinct.
                        if (r_bit_cnt != C_SAT) begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_sck_fall) begin
                        // Zeros shift in behind the word, so sdo drops to 0
                        // by itself once every tx bit has been sent.
                        w_tx_sh_nxt = r_tx_sh << 1;
                        w_sdo_nxt   = r_tx_sh[FRAME_BITS-2];
                    end
                end
            end

            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_sdo_nxt   = 1'b0;
                if (r_bit_cnt == C_FULL) begin
                    w_frame_data_nxt  = r_rx_sh;
                    w_frame_valid_nxt = 1'b1;
                    w_frame_count_nxt = r_frame_count + 8'd1;
                end else begin
                    w_frame_err_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_sdo_nxt   = 1'b0;
            end
        endcase
    end

    assign o_sdo         = r_sdo;
    assign o_frame_data  = r_frame_data;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;
    assign o_busy        = r_busy;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_ctrl
//   Drives mode-0 SPI frames at sck = clk/8 into spi_frame_ctrl and compares
//   every frame against a frame-level model: a frame is valid only when its
//   bit count equals FRAME_BITS, the valid count wraps modulo 256, and the
//   master must see tx_word MSB-first followed by zeros.
// -----------------------------------------------------------------------------
module tb_spi_frame_ctrl;

    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          rst_raw = 1'b0;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          nss = 1'b1;
    logic [FB-1:0] tx_word = '0;
    logic          sdo;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_err;
    logic          busy;
    logic [7:0]    frame_count;

    spi_frame_ctrl #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_rst_raw     (rst_raw),
        .i_sck         (sck),
        .i_sdi         (sdi),
        .i_nss         (nss),
        .o_sdo         (sdo),
        .i_tx_word     (tx_word),
        .o_frame_data  (frame_data),
        .o_frame_valid (frame_valid),
        .o_frame_err   (frame_err),
        .o_busy        (busy),
        .o_frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_count = 0;
    logic [15:0] m_data = '0;
    int         total_valid = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_raw = 1'b0;
        clks(n);
        rst_raw = 1'b1;
        m_count = 0;
        m_data  = '0;
    endtask

    task automatic start_frame(input logic [15:0] tx);
        tx_word = tx;
        nss     = 1'b0;
        clks(4);
    endtask

    // Master: drive sdi while sck is low, sample sdo at the rising edge.
    task automatic send_bits(input int n, input logic [31:0] data, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            sdi = data[n-1-i];
            clks(4);
            sck = 1'b1;
            cap = {cap[30:0], sdo};
            clks(4);
            sck = 1'b0;
        end
        sdi = 1'b0;
    endtask

    task automatic end_frame(output int nv, output int ne, output int nb);
        clks(4);
        nss = 1'b1;
        nv = 0;
        ne = 0;
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (frame_valid) nv++;
            if (frame_err) ne++;
            if (frame_valid && frame_err) nb++;
        end
    endtask

    task automatic run_frame(input string tag, input int n, input logic [31:0] data,
                             input logic [15:0] tx);
        logic [31:0] cap;
        logic [31:0] exp_sdo;
        logic        b;
        int          nv, ne, nb;
        start_frame(tx);
        send_bits(n, data, cap);
        end_frame(nv, ne, nb);

        exp_sdo = '0;
        for (int i = 0; i < n; i++) begin
            b = 1'b0;
            if (i < FB) b = tx[FB-1-i];
            exp_sdo = {exp_sdo[30:0], b};
        end
        if (n == FB) begin
            m_count = (m_count + 1) % 256;
            m_data  = data[15:0];
            total_valid++;
        end

        check_val({tag, ".valid"}, nv, (n == FB) ? 1 : 0);
        check_val({tag, ".err"},   ne, (n == FB) ? 0 : 1);
        check_val({tag, ".both"},  nb, 0);
        check_val({tag, ".data"},  frame_data, m_data);
        check_val({tag, ".count"}, frame_count, m_count);
        check_val({tag, ".sdo_rx"}, cap, exp_sdo);
        check_val({tag, ".sdo_idle"}, sdo, 0);
        check_val({tag, ".busy"},  busy, 0);
    endtask

    initial begin
        logic [31:0] cap;
        logic [31:0] d;
        int          nv, ne, nb, n;

        // Reset held with random pin activity.
        rst_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            {sck, sdi, nss} = 3'($urandom);
            @(negedge clk);
            check_val("rst.sdo",   sdo, 0);
            check_val("rst.data",  frame_data, 0);
            check_val("rst.valid", frame_valid, 0);
            check_val("rst.err",   frame_err, 0);
            check_val("rst.busy",  busy, 0);
            check_val("rst.count", frame_count, 0);
        end
        sck = 1'b0;
        sdi = 1'b0;
        nss = 1'b1;
        rst_raw = 1'b1;
        clks(6);
        check_val("post_rst.busy",  busy, 0);
        check_val("post_rst.sdo",   sdo, 0);
        check_val("post_rst.count", frame_count, 0);

        // Nominal frame, then short and long frames, then recovery.
        run_frame("t2", 16, 32'h0000_A5C3, 16'h1234);
        run_frame("t3", 15, $urandom, 16'($urandom));
        run_frame("t4a", 17, $urandom, 16'($urandom));
        run_frame("t4b", 16, 32'h0000_00FF, 16'($urandom));

        // Reset in the middle of a frame: that frame must vanish silently.
        start_frame(16'($urandom));
        send_bits(8, $urandom, cap);
        do_reset(2);
        send_bits(8, $urandom, cap);
        end_frame(nv, ne, nb);
        check_val("t5.valid", nv, 0);
        check_val("t5.err",   ne, 0);
        check_val("t5.count", frame_count, m_count);
        check_val("t5.busy",  busy, 0);
        run_frame("t5b", 16, 32'h0000_0001, 16'($urandom));

        // Zero-bit frame.
        run_frame("zero", 0, 32'h0, 16'($urandom));

        // Random lengths and contents.
        for (int i = 0; i < 14; i++) begin
            n = ($urandom % 2 == 0) ? 16 : int'($urandom_range(0, 18));
            run_frame("rnd", n, $urandom, 16'($urandom));
        end

        // 256 back-to-back valid frames from a fresh reset: count wraps to 0.
        do_reset(2);
        clks(4);
        total_valid = 0;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            run_frame("t6", 16, d, 16'($urandom));
        end
        check_val("t6.total", total_valid, 256);
        check_val("t6.count_wrap", frame_count, 0);
        check_val("t6.last_data", frame_data, d[15:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
